// File: rtl/lpif_tx_protid_arbiter.sv
// Round-robin, packet-locked arbiter sharing the LPIF downstream channel
// between protocol-layer requesters, with credit flow control against the TX FIFO.
module lpif_tx_protid_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_W     = 32,
    parameter int CREDIT_MAX = 8
) (
    input  logic                          clk_wr,
    input  logic                          rst_wr_n,
    input  logic                          m_gen2_mode,
    input  logic [3:0]                    lp_state,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          credit_return,
    output logic [3:0]                    dstrm_state,
    output logic [1:0]                    dstrm_protid,
    output logic [DATA_W-1:0]             dstrm_data,
    output logic                          dstrm_dvalid,
    output logic                          dstrm_crc,
    output logic                          dstrm_crc_valid,
    output logic                          dstrm_valid,
    output logic [$clog2(CREDIT_MAX):0]   credit_cnt,
    output logic                          credit_err
);

    localparam int CW = $clog2(CREDIT_MAX) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        if (idx >= 2'(NUM_REQ - 1)) begin
            next_idx = 2'd0;
        end else begin
            next_idx = idx + 2'd1;
        end
    endfunction

    // Returns {found, index} of the first valid requester at or after ptr.
    function automatic logic [2:0] rr_search(input logic [3:0] valid, input logic [1:0] ptr);
        logic [2:0] sum;
        logic [1:0] cand;
        rr_search = 3'b000;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + 3'(k);
            if (sum >= 3'(NUM_REQ)) begin
                sum = sum - 3'(NUM_REQ);
            end
            cand = sum[1:0];
            if (!rr_search[2] && valid[cand]) begin
                rr_search = {1'b1, cand};
            end
        end
    endfunction

    state_t              state_r;
    logic [1:0]          gnt_idx_r;
    logic [1:0]          rr_ptr_r;
    logic                bubble_r;
    logic [CW-1:0]       credit_r;
    logic                credit_err_r;
    logic [3:0]          state_out_r;
    logic [1:0]          protid_r;
    logic [DATA_W-1:0]   data_r;
    logic                valid_r;

    logic [3:0]          valid4_s;
    logic [3:0]          last4_s;
    logic [DATA_W-1:0]   data_arr_s [4];
    logic [2:0]          arb_s;
    logic                grant_valid_s;
    logic [1:0]          grant_idx_s;
    logic [3:0]          ready4_s;
    logic                accept_s;
    logic                accept_last_s;
    logic [CW-1:0]       pool_max_s;

    assign valid4_s   = 4'(req_valid);
    assign last4_s    = 4'(req_last);
    assign pool_max_s = m_gen2_mode ? CW'(CREDIT_MAX) : CW'(CREDIT_MAX / 2);

    for (genvar g = 0; g < 4; g++) begin : g_norm
        if (g < NUM_REQ) begin : g_used
            assign data_arr_s[g] = req_data[g*DATA_W +: DATA_W];
        end else begin : g_unused
            assign data_arr_s[g] = {DATA_W{1'b0}};
        end
    end

    // Grant selection, ready generation and beat acceptance.
    always_comb begin
        arb_s         = rr_search(valid4_s, rr_ptr_r);
        grant_valid_s = 1'b0;
        grant_idx_s   = 2'd0;
        case (state_r)
            IDLE: begin
                grant_valid_s = !bubble_r && arb_s[2];
                grant_idx_s   = arb_s[1:0];
            end
            LOCK: begin
                grant_valid_s = 1'b1;
                grant_idx_s   = gnt_idx_r;
            end
            default: begin
                grant_valid_s = 1'b0;
                grant_idx_s   = 2'd0;
            end
        endcase
        // Reset gating keeps req_ready low while the block is held in reset.
        if (grant_valid_s && (credit_r != {CW{1'b0}}) && rst_wr_n) begin
            ready4_s = 4'b0001 << grant_idx_s;
        end else begin
            ready4_s = 4'b0000;
        end
        accept_s      = |(ready4_s & valid4_s);
        accept_last_s = accept_s && last4_s[grant_idx_s];
    end

    assign req_ready = ready4_s[NUM_REQ-1:0];

    // Arbitration FSM: lock on grant, release on the last accepted beat, then one bubble.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state_r   <= IDLE;
            gnt_idx_r <= 2'd0;
            rr_ptr_r  <= 2'd0;
            bubble_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    bubble_r <= 1'b0;
                    if (grant_valid_s) begin
                        gnt_idx_r <= grant_idx_s;
                        if (accept_last_s) begin
                            state_r  <= IDLE;
                            rr_ptr_r <= next_idx(grant_idx_s);
                            bubble_r <= 1'b1;
                        end else begin
                            state_r <= LOCK;
                        end
                    end
                end
                LOCK: begin
                    if (accept_last_s) begin
                        state_r  <= IDLE;
                        rr_ptr_r <= next_idx(gnt_idx_r);
                        bubble_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    bubble_r <= 1'b0;
                end
            endcase
        end
    end

    // Credit pool: decrement on accept, increment on return, saturate and flag overflow.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            credit_r     <= pool_max_s;
            credit_err_r <= 1'b0;
        end else begin
            case ({accept_s, credit_return})
                2'b10: credit_r <= credit_r - CW'(1);
                2'b01: begin
                    if (credit_r == pool_max_s) begin
                        credit_err_r <= 1'b1;
                    end else begin
                        credit_r <= credit_r + CW'(1);
                    end
                end
                default: credit_r <= credit_r;
            endcase
        end
    end

    // Downstream channel registers; payload and protid hold between beats.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state_out_r <= 4'd0;
            protid_r    <= 2'd0;
            data_r      <= {DATA_W{1'b0}};
            valid_r     <= 1'b0;
        end else begin
            state_out_r <= lp_state;
            valid_r     <= accept_s;
            if (accept_s) begin
                protid_r <= grant_idx_s;
                data_r   <= data_arr_s[grant_idx_s];
            end
        end
    end

    assign dstrm_state     = state_out_r;
    assign dstrm_protid    = protid_r;
    assign dstrm_data      = data_r;
    assign dstrm_valid     = valid_r;
    assign dstrm_dvalid    = valid_r;
    assign dstrm_crc       = 1'b0;
    assign dstrm_crc_valid = 1'b0;
    assign credit_cnt      = credit_r;
    assign credit_err      = credit_err_r;

endmodule

// File: tb/tb_lpif_tx_protid_arbiter.sv
// Directed bench for lpif_tx_protid_arbiter: a per-cycle reference model checked
// on every falling edge, plus hand-computed expectations for each scenario.
module tb_lpif_tx_protid_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int CM = 8;
    localparam int CW = $clog2(CM) + 1;

    logic            clk_wr = 1'b0;
    logic            rst_wr_n;
    logic            m_gen2_mode;
    logic [3:0]      lp_state;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            credit_return;
    logic [3:0]      dstrm_state;
    logic [1:0]      dstrm_protid;
    logic [DW-1:0]   dstrm_data;
    logic            dstrm_dvalid;
    logic            dstrm_crc;
    logic            dstrm_crc_valid;
    logic            dstrm_valid;
    logic [CW-1:0]   credit_cnt;
    logic            credit_err;

    lpif_tx_protid_arbiter #(.NUM_REQ(N), .DATA_W(DW), .CREDIT_MAX(CM)) dut (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .m_gen2_mode(m_gen2_mode), .lp_state(lp_state),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
        .credit_return(credit_return), .dstrm_state(dstrm_state), .dstrm_protid(dstrm_protid),
        .dstrm_data(dstrm_data), .dstrm_dvalid(dstrm_dvalid), .dstrm_crc(dstrm_crc),
        .dstrm_crc_valid(dstrm_crc_valid), .dstrm_valid(dstrm_valid),
        .credit_cnt(credit_cnt), .credit_err(credit_err)
    );

    always #5 clk_wr = ~clk_wr;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int          m_owner = -1;
    bit          m_gap   = 1'b0;
    int          m_rr    = 0;
    int          m_cred  = CM;
    int          m_pool  = CM;
    bit          m_err   = 1'b0;
    bit          m_valid = 1'b0;
    int          m_protid = 0;
    logic [DW-1:0] m_data = '0;
    logic [3:0]  m_state = 4'd0;
    int          cyc = 0;
    int          beat_pid[$];
    int          beat_cyc[$];

    always @(negedge clk_wr) begin : model_p
        int g;
        bit acc;
        logic [N-1:0] exp_r;
        cyc++;
        if (!rst_wr_n) begin
            m_owner = -1; m_gap = 1'b0; m_rr = 0; m_err = 1'b0;
            m_pool  = m_gen2_mode ? CM : CM / 2;
            m_cred  = m_pool;
            m_valid = 1'b0; m_protid = 0; m_data = '0;
            check("rst_valid", dstrm_valid, 0);
            check("rst_protid", dstrm_protid, 0);
            check("rst_data", dstrm_data, 0);
            check("rst_state", dstrm_state, 0);
            check("rst_ready", req_ready, 0);
            check("rst_credit", credit_cnt, m_pool);
            check("rst_err", credit_err, 0);
        end else begin
            check("m_valid", dstrm_valid, m_valid);
            check("m_dvalid", dstrm_dvalid, m_valid);
            check("m_protid", dstrm_protid, m_protid);
            check("m_data", dstrm_data, m_data);
            check("m_credit", credit_cnt, m_cred);
            check("m_err", credit_err, m_err);
            check("m_crc", {dstrm_crc, dstrm_crc_valid}, 0);
            if (m_valid) check("m_state", dstrm_state, m_state);
            if (dstrm_valid) begin
                beat_pid.push_back(int'(dstrm_protid));
                beat_cyc.push_back(cyc);
            end
            g = -1;
            if (m_owner >= 0) g = m_owner;
            else if (!m_gap) begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
            exp_r = '0;
            if (g >= 0 && m_cred > 0) exp_r[g] = 1'b1;
            check("m_ready", req_ready, exp_r);
            acc = (g >= 0) && (m_cred > 0) && req_valid[g];
            m_gap   = 1'b0;
            m_owner = g;
            if (acc) begin
                m_valid  = 1'b1;
                m_protid = g;
                m_data   = req_data[g*DW +: DW];
                m_state  = lp_state;
                if (req_last[g]) begin
                    m_owner = -1;
                    m_gap   = 1'b1;
                    m_rr    = (g + 1) % N;
                end
            end else begin
                m_valid = 1'b0;
            end
            if (credit_return && !acc) begin
                if (m_cred == m_pool) m_err = 1'b1;
                else m_cred++;
            end else if (acc && !credit_return) begin
                m_cred--;
            end
        end
    end

    task automatic step();
        @(posedge clk_wr);
        #2;
        lp_state = lp_state + 4'd1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l);
        req_valid = v;
        req_last  = l;
    endtask

    task automatic do_reset(input logic gen2);
        step();
        drive(2'b00, 2'b00);
        credit_return = 1'b0;
        m_gen2_mode   = gen2;
        rst_wr_n      = 1'b0;
        step();
        step();
        rst_wr_n = 1'b1;
        beat_pid.delete();
        beat_cyc.delete();
    endtask

    initial begin
        rst_wr_n = 1'b0; m_gen2_mode = 1'b1; lp_state = 4'd0;
        req_valid = '0; req_last = '0; req_data = '0; credit_return = 1'b0;

        // Single beat, gen2
        do_reset(1'b1);
        req_data = {32'hB5B5_0002, 32'hA5A5_0001};
        drive(2'b01, 2'b01);
        #1;
        check("t1_ready_same_cycle", req_ready, 2'b01);
        check("t1_credit_before", credit_cnt, 8);
        step();
        drive(2'b00, 2'b00);
        #1;
        check("t1_dvalid", dstrm_valid, 1);
        check("t1_protid", dstrm_protid, 0);
        check("t1_data", dstrm_data, 32'hA5A5_0001);
        check("t1_credit_after", credit_cnt, 7);

        // Round robin with single-beat packets
        do_reset(1'b1);
        req_data = {32'hB000_0001, 32'hA000_0000};
        drive(2'b11, 2'b11);
        repeat (8) step();
        drive(2'b00, 2'b00);
        step(); step();
        check("t2_beats", beat_pid.size(), 4);
        if (beat_pid.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t2_protid_seq", beat_pid[i], i % 2);
            for (int i = 1; i < 4; i++) check("t2_bubble", beat_cyc[i] - beat_cyc[i-1], 2);
        end

        // Packet lock: 3-beat packet from req0 with req1 waiting
        do_reset(1'b1);
        req_data = {32'hB000_0002, 32'hA000_0001};
        drive(2'b11, 2'b00);
        step();
        #1 check("t3_lock_ready", req_ready, 2'b01);
        drive(2'b10, 2'b00);
        #1 check("t3_drop_keeps_lock", req_ready, 2'b01);
        step();
        drive(2'b11, 2'b00);
        step();
        drive(2'b11, 2'b01);
        step();
        drive(2'b10, 2'b10);
        #1 check("t3_bubble_ready", req_ready, 2'b00);
        step();
        #1 check("t3_next_grant", req_ready, 2'b10);
        step();
        drive(2'b00, 2'b00);
        step(); step();
        check("t3_beats", beat_pid.size(), 4);
        if (beat_pid.size() == 4) begin
            check("t3_b0", beat_pid[0], 0);
            check("t3_b1", beat_pid[1], 0);
            check("t3_b2", beat_pid[2], 0);
            check("t3_b3", beat_pid[3], 1);
            check("t3_consec", beat_cyc[2] - beat_cyc[1], 1);
        end

        // Credit exhaustion in gen1
        do_reset(1'b0);
        #1 check("t4_gen1_pool", credit_cnt, 4);
        req_data = {32'hB000_0004, 32'hA000_0004};
        drive(2'b01, 2'b00);
        repeat (8) step();
        #1;
        check("t4_beats_4", beat_pid.size(), 4);
        check("t4_ready_zero", req_ready, 2'b00);
        check("t4_credit_zero", credit_cnt, 0);
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        repeat (4) step();
        #1;
        check("t4_beats_5", beat_pid.size(), 5);
        check("t4_credit_zero2", credit_cnt, 0);
        credit_return = 1'b1;
        step();
        #1 check("t4_ready_one", req_ready, 2'b01);
        step();
        credit_return = 1'b0;
        #1 check("t4_same_cycle", credit_cnt, 1);
        step();
        #1 check("t4_credit_end", credit_cnt, 0);

        // Overflow at full pool
        do_reset(1'b1);
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        #1;
        check("t5_sat", credit_cnt, 8);
        check("t5_err", credit_err, 1);
        repeat (3) step();
        #1 check("t5_err_sticky", credit_err, 1);
        do_reset(1'b1);
        #1 check("t5_err_clear", credit_err, 0);

        // Reset mid-packet
        do_reset(1'b1);
        req_data = {32'hB000_0006, 32'hC000_0001};
        drive(2'b01, 2'b00);
        step();
        #1 check("t6_beat1", dstrm_valid, 1);
        #1;
        rst_wr_n = 1'b0;
        #1;
        check("t6_async_valid", dstrm_valid, 0);
        check("t6_async_data", dstrm_data, 0);
        check("t6_async_ready", req_ready, 0);
        check("t6_async_credit", credit_cnt, 8);
        step();
        step();
        rst_wr_n = 1'b1;
        drive(2'b11, 2'b11);
        #1 check("t6_grant_from_0", req_ready, 2'b01);
        step();
        drive(2'b00, 2'b00);
        #1 check("t6_protid", dstrm_protid, 0);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
